// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshake and broadcast bus bundle for cdb_arbiter.
//   src_valid/src_ready  per-source valid/ready handshake (NUM_SRC bits)
//   src_lab/src_val      per-source ROB label / value, source i at [i*W +: W]
//   cdb_en               per-bus broadcast valid (NUM_BUS bits)
//   cdb_lab/cdb_val      per-bus broadcast label / value, bus k at [k*W +: W]
//   cdb_src              per-bus granted source index (debug/verification)
// master: producers and consumers; slave: the arbiter itself.
interface cdb_arbiter_if #(
  parameter int NUM_SRC      = 2,
  parameter int NUM_BUS      = 1,
  parameter int ROB_ID_WIDTH = 4,
  parameter int VAL_WIDTH    = 32
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]              src_valid;
  logic [NUM_SRC-1:0]              src_ready;
  logic [NUM_SRC*ROB_ID_WIDTH-1:0] src_lab;
  logic [NUM_SRC*VAL_WIDTH-1:0]    src_val;
  logic [NUM_BUS-1:0]              cdb_en;
  logic [NUM_BUS*ROB_ID_WIDTH-1:0] cdb_lab;
  logic [NUM_BUS*VAL_WIDTH-1:0]    cdb_val;
  logic [NUM_BUS*SRC_W-1:0]        cdb_src;

  modport master (
    output src_valid, src_lab, src_val,
    input  src_ready, cdb_en, cdb_lab, cdb_val, cdb_src
  );

  modport slave (
    input  src_valid, src_lab, src_val,
    output src_ready, cdb_en, cdb_lab, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus. Each of NUM_SRC producers owns a FIFO_DEPTH
// queue; a round-robin arbiter grants up to NUM_BUS distinct non-empty queues
// per cycle and registers their heads onto the broadcast buses.
//   clk     system clock, rising edge
//   rst_in  asynchronous reset, active-low
//   rdy_in  global enable; 0 freezes all state and outputs
//   flush   synchronous flush: empties queues, clears outputs, rr_ptr=0
//   bus     cdb_arbiter_if.slave: source handshakes and broadcast buses
module cdb_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int NUM_BUS      = 1,
  parameter int ROB_ID_WIDTH = 4,
  parameter int VAL_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_ID_WIDTH + VAL_WIDTH;

  logic [ENT_W-1:0] mem   [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr  [NUM_SRC];
  logic [PTR_W-1:0] rptr  [NUM_SRC];
  logic [CNT_W-1:0] count [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [NUM_BUS-1:0] grant_hit;
  logic [SRC_W-1:0]   grant_idx [NUM_BUS];
  logic [ENT_W-1:0]   grant_ent [NUM_BUS];

  logic [NUM_BUS-1:0]              en_q;
  logic [NUM_BUS*ROB_ID_WIDTH-1:0] lab_q;
  logic [NUM_BUS*VAL_WIDTH-1:0]    val_q;
  logic [NUM_BUS*SRC_W-1:0]        src_q;

  // Ready comes only from the registered count: a full queue stays not-ready
  // even in a cycle where it is also being popped.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      push[i]  = bus.src_valid[i] && ready[i];
    end
  end

  // Rotating scan starting at rr_ptr; the j-th non-empty queue found drives
  // bus j. The inner loop maps the rotated position back to a constant index
  // so every select stays a plain constant-bounded one.
  always_comb begin
    int unsigned idx;
    int unsigned gcnt;
    idx       = 0;
    gcnt      = 0;
    pop       = '0;
    grant_hit = '0;
    rr_next   = rr_ptr;
    for (int unsigned j = 0; j < NUM_BUS; j++) grant_idx[j] = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (i == idx && count[i] != '0 && gcnt < NUM_BUS) begin
          pop[i] = 1'b1;
          for (int unsigned j = 0; j < NUM_BUS; j++) begin
            if (j == gcnt) begin
              grant_hit[j] = 1'b1;
              grant_idx[j] = SRC_W'(i);
            end
          end
          rr_next = (i == NUM_SRC - 1) ? '0 : SRC_W'(i + 1);
          gcnt    = gcnt + 1;
        end
      end
    end
  end

  // Head of the granted queue per bus; idle buses carry zero.
  always_comb begin
    for (int unsigned j = 0; j < NUM_BUS; j++) begin
      grant_ent[j] = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grant_hit[j] && grant_idx[j] == SRC_W'(i)) grant_ent[j] = mem[i][rptr[i]];
      end
    end
  end

  // Storage carries no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rdy_in && !flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= {bus.src_lab[i*ROB_ID_WIDTH +: ROB_ID_WIDTH],
                              bus.src_val[i*VAL_WIDTH +: VAL_WIDTH]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr <= '0;
      en_q   <= '0;
      lab_q  <= '0;
      val_q  <= '0;
      src_q  <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      rr_ptr <= '0;
      en_q   <= '0;
      lab_q  <= '0;
      val_q  <= '0;
      src_q  <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (rdy_in) begin
      rr_ptr <= rr_next;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
      en_q <= grant_hit;
      for (int unsigned j = 0; j < NUM_BUS; j++) begin
        lab_q[j*ROB_ID_WIDTH +: ROB_ID_WIDTH] <= grant_ent[j][ENT_W-1 -: ROB_ID_WIDTH];
        val_q[j*VAL_WIDTH +: VAL_WIDTH]       <= grant_ent[j][VAL_WIDTH-1:0];
        src_q[j*SRC_W +: SRC_W]               <= grant_idx[j];
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.cdb_en    = en_q;
  assign bus.cdb_lab   = lab_q;
  assign bus.cdb_val   = val_q;
  assign bus.cdb_src   = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 2-source/1-bus instance and a 4-source/2-bus
// instance. Directed stimulus pushes hand-ordered expected broadcasts into
// per-bus queues; negedge monitors pop and compare every new broadcast.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst2, rdy2, flush2;
  logic rst4, rdy4, flush4;
  logic e_rdy2, e_rdy4;

  cdb_arbiter_if #(.NUM_SRC(2), .NUM_BUS(1), .ROB_ID_WIDTH(4), .VAL_WIDTH(32)) b2 ();
  cdb_arbiter_if #(.NUM_SRC(4), .NUM_BUS(2), .ROB_ID_WIDTH(4), .VAL_WIDTH(32)) b4 ();

  cdb_arbiter #(.NUM_SRC(2), .NUM_BUS(1), .ROB_ID_WIDTH(4), .VAL_WIDTH(32), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_in(rst2), .rdy_in(rdy2), .flush(flush2), .bus(b2)
  );
  cdb_arbiter #(.NUM_SRC(4), .NUM_BUS(2), .ROB_ID_WIDTH(4), .VAL_WIDTH(32), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_in(rst4), .rdy_in(rdy4), .flush(flush4), .bus(b4)
  );

  // Expected broadcast: {src[1:0], lab[3:0], val[31:0]}
  logic [37:0] exp2 [$];
  logic [37:0] exp40 [$];
  logic [37:0] exp41 [$];

  function automatic logic [31:0] vf(input int t);
    return 32'hC0DE_0000 + 32'(t);
  endfunction

  function automatic logic [37:0] ent(input int s, input int t);
    return {2'(s), 4'(t % 16), vf(t)};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Only edges taken with rdy_in=1 produce a new broadcast.
  always @(posedge clk) begin
    e_rdy2 <= rdy2;
    e_rdy4 <= rdy4;
  end

  always @(negedge clk) begin
    logic [37:0] act;
    if (rst2 === 1'b1 && e_rdy2 === 1'b1 && b2.cdb_en[0] === 1'b1) begin
      act = {2'(b2.cdb_src), b2.cdb_lab, b2.cdb_val};
      if (exp2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected actual=0x%0h required=none", act);
      end else chk("d2_bcast", 64'(act), 64'(exp2.pop_front()));
    end
  end

  always @(negedge clk) begin
    logic [37:0] act;
    if (rst4 === 1'b1 && e_rdy4 === 1'b1) begin
      if (b4.cdb_en[0] === 1'b1) begin
        act = {b4.cdb_src[1:0], b4.cdb_lab[3:0], b4.cdb_val[31:0]};
        if (exp40.size() == 0) begin
          checks++; errors++;
          $display("FAIL d4_bus0_unexpected actual=0x%0h required=none", act);
        end else chk("d4_bus0", 64'(act), 64'(exp40.pop_front()));
      end
      if (b4.cdb_en[1] === 1'b1) begin
        act = {b4.cdb_src[3:2], b4.cdb_lab[7:4], b4.cdb_val[63:32]};
        if (exp41.size() == 0) begin
          checks++; errors++;
          $display("FAIL d4_bus1_unexpected actual=0x%0h required=none", act);
        end else chk("d4_bus1", 64'(act), 64'(exp41.pop_front()));
      end
    end
  end

  // Two-source producer with proper valid/ready: an item advances only when
  // valid met ready (ready is registered, so its negedge value holds at the edge).
  task automatic stream2(input int n0, input int t0, input int n1, input int t1, output bit blocked1);
    int s0 = 0;
    int s1 = 0;
    int guard = 0;
    logic [1:0] r;
    blocked1 = 1'b0;
    while ((s0 < n0 || s1 < n1) && guard < 200) begin
      b2.src_valid[0]  = (s0 < n0);
      b2.src_lab[3:0]  = 4'((t0 + s0) % 16);
      b2.src_val[31:0] = vf(t0 + s0);
      b2.src_valid[1]  = (s1 < n1);
      b2.src_lab[7:4]  = 4'((t1 + s1) % 16);
      b2.src_val[63:32] = vf(t1 + s1);
      r = b2.src_ready;
      if (b2.src_valid[1] && !r[1]) blocked1 = 1'b1;
      @(negedge clk);
      if (b2.src_valid[0] && r[0]) s0++;
      if (b2.src_valid[1] && r[1]) s1++;
      guard++;
    end
    b2.src_valid = '0;
    chk("stream2_accept_budget", 64'(guard < 200), 64'(1));
  endtask

  task automatic drain2(input int budget, input string name);
    int n = 0;
    while (exp2.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp2.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic drain4(input int budget, input string name);
    int n = 0;
    while ((exp40.size() != 0 || exp41.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp40.size() + exp41.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic drive4(input int s, input int t);
    b4.src_valid[s]         = 1'b1;
    b4.src_lab[s*4 +: 4]    = 4'(t % 16);
    b4.src_val[s*32 +: 32]  = vf(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit blk;
    rst2 = 1'b0; rdy2 = 1'b1; flush2 = 1'b0;
    rst4 = 1'b0; rdy4 = 1'b1; flush4 = 1'b0;
    b2.src_valid = '0; b2.src_lab = '0; b2.src_val = '0;
    b4.src_valid = '0; b4.src_lab = '0; b4.src_val = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_d2_en",  64'(b2.cdb_en),  64'(0));
    chk("rst_d2_lab", 64'(b2.cdb_lab), 64'(0));
    chk("rst_d2_val", 64'(b2.cdb_val), 64'(0));
    chk("rst_d2_src", 64'(b2.cdb_src), 64'(0));
    chk("rst_d4_en",  64'(b4.cdb_en),  64'(0));
    chk("rst_d4_val", 64'(b4.cdb_val), 64'(0));
    rst2 = 1'b1; rst4 = 1'b1;
    @(negedge clk);
    chk("rst_d2_ready", 64'(b2.src_ready), 64'(2'b11));
    chk("rst_d4_ready", 64'(b4.src_ready), 64'(4'hF));

    // Single push: two-edge latency, one-cycle broadcast
    b2.src_valid = 2'b01; b2.src_lab[3:0] = 4'd3; b2.src_val[31:0] = 32'h0000_DEAD;
    exp2.push_back({2'd0, 4'd3, 32'h0000_DEAD});
    @(negedge clk);
    b2.src_valid = '0;
    chk("t1_en_after_edge1", 64'(b2.cdb_en), 64'(0));
    @(negedge clk);
    chk("t1_en_after_edge2", 64'(b2.cdb_en), 64'(1));
    @(negedge clk);
    chk("t1_en_after_edge3", 64'(b2.cdb_en), 64'(0));
    chk("t1_lab_idle", 64'(b2.cdb_lab), 64'(0));

    // Idle flush pulse returns rr_ptr to 0
    flush2 = 1'b1;
    @(negedge clk);
    flush2 = 1'b0;
    @(negedge clk);
    chk("t1_flush_ready", 64'(b2.src_ready), 64'(2'b11));

    // Both sources stream 8 entries: strict alternation, backpressure, no loss
    for (int k = 0; k < 8; k++) begin
      exp2.push_back(ent(0, k));
      exp2.push_back(ent(1, 8 + k));
    end
    stream2(8, 0, 8, 8, blk);
    chk("t2_src1_backpressure", 64'(blk), 64'(1));
    drain2(40, "t2_drain");

    // src1 fills to 4 behind src0 and holds its 7th entry until space frees
    exp2.push_back(ent(0, 100)); exp2.push_back(ent(1, 110));
    exp2.push_back(ent(0, 101)); exp2.push_back(ent(1, 111));
    exp2.push_back(ent(0, 102)); exp2.push_back(ent(1, 112));
    exp2.push_back(ent(0, 103)); exp2.push_back(ent(1, 113));
    exp2.push_back(ent(1, 114)); exp2.push_back(ent(1, 115));
    exp2.push_back(ent(1, 116));
    stream2(4, 100, 7, 110, blk);
    chk("t3_src1_full", 64'(blk), 64'(1));
    drain2(40, "t3_drain");

    // Flush with 3 queued and a live broadcast; same-cycle push is dropped
    b2.src_valid = 2'b11;
    b2.src_lab = {4'(130 % 16), 4'(120 % 16)}; b2.src_val = {vf(130), vf(120)};
    exp2.push_back(ent(0, 120));
    @(negedge clk);
    b2.src_lab = {4'(131 % 16), 4'(121 % 16)}; b2.src_val = {vf(131), vf(121)};
    @(negedge clk);
    chk("t4_en_before_flush", 64'(b2.cdb_en), 64'(1));
    flush2 = 1'b1;
    b2.src_valid = 2'b01; b2.src_lab[3:0] = 4'(140 % 16); b2.src_val[31:0] = vf(140);
    @(negedge clk);
    flush2 = 1'b0; b2.src_valid = '0;
    chk("t4_en_at_flush", 64'(b2.cdb_en), 64'(0));
    chk("t4_lab_at_flush", 64'(b2.cdb_lab), 64'(0));
    chk("t4_val_at_flush", 64'(b2.cdb_val), 64'(0));
    chk("t4_ready_after_flush", 64'(b2.src_ready), 64'(2'b11));
    repeat (4) @(negedge clk);
    chk("t4_quiet_after_flush", 64'(b2.cdb_en), 64'(0));
    b2.src_valid = 2'b11;
    b2.src_lab = {4'(160 % 16), 4'(150 % 16)}; b2.src_val = {vf(160), vf(150)};
    exp2.push_back(ent(0, 150)); exp2.push_back(ent(1, 160));
    @(negedge clk);
    b2.src_valid = '0;
    drain2(10, "t4_drain");

    // rdy_in low for 5 cycles freezes outputs and queues
    b2.src_valid = 2'b11;
    b2.src_lab = {4'(180 % 16), 4'(170 % 16)}; b2.src_val = {vf(180), vf(170)};
    exp2.push_back(ent(0, 170));
    @(negedge clk);
    b2.src_lab = {4'(181 % 16), 4'(171 % 16)}; b2.src_val = {vf(181), vf(171)};
    @(negedge clk);
    rdy2 = 1'b0;
    b2.src_valid = 2'b01; b2.src_lab[3:0] = 4'(190 % 16); b2.src_val[31:0] = vf(190);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_frozen_en",  64'(b2.cdb_en),  64'(1));
      chk("t5_frozen_lab", 64'(b2.cdb_lab), 64'(170 % 16));
      chk("t5_frozen_val", 64'(b2.cdb_val), 64'(vf(170)));
      chk("t5_frozen_src", 64'(b2.cdb_src), 64'(0));
      chk("t5_frozen_rdy", 64'(b2.src_ready), 64'(2'b11));
    end
    rdy2 = 1'b1; b2.src_valid = '0;
    exp2.push_back(ent(1, 180)); exp2.push_back(ent(0, 171)); exp2.push_back(ent(1, 181));
    drain2(10, "t5_drain");

    // 4 sources, 2 buses: pairs {0,1},{2,3},{0,1}; async reset mid-burst
    for (int s = 0; s < 4; s++) drive4(s, 200 + s * 4);
    exp40.push_back(ent(0, 200)); exp41.push_back(ent(1, 204));
    exp40.push_back(ent(2, 208)); exp41.push_back(ent(3, 212));
    exp40.push_back(ent(0, 201)); exp41.push_back(ent(1, 205));
    @(negedge clk);
    for (int s = 0; s < 4; s++) drive4(s, 201 + s * 4);
    @(negedge clk);
    b4.src_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_en_before_rst", 64'(b4.cdb_en), 64'(2'b11));
    #2;
    rst4 = 1'b0;
    #1;
    chk("t6_async_en",  64'(b4.cdb_en),  64'(0));
    chk("t6_async_lab", 64'(b4.cdb_lab), 64'(0));
    chk("t6_async_val", 64'(b4.cdb_val), 64'(0));
    chk("t6_async_src", 64'(b4.cdb_src), 64'(0));
    exp40.delete(); exp41.delete();
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_rst", 64'(b4.src_ready), 64'(4'hF));
    chk("t6_quiet_after_rst", 64'(b4.cdb_en), 64'(0));

    // Sparse grants: s1,s3 share a cycle; a lone s2 leaves bus 1 idle and zero
    drive4(1, 220); drive4(3, 230);
    exp40.push_back(ent(1, 220)); exp41.push_back(ent(3, 230));
    @(negedge clk);
    b4.src_valid = '0;
    @(negedge clk);
    drive4(2, 240);
    exp40.push_back(ent(2, 240));
    @(negedge clk);
    b4.src_valid = '0;
    @(negedge clk);
    chk("t6_single_en",   64'(b4.cdb_en),        64'(2'b01));
    chk("t6_idle_bus_lab", 64'(b4.cdb_lab[7:4]),  64'(0));
    chk("t6_idle_bus_val", 64'(b4.cdb_val[63:32]), 64'(0));
    chk("t6_idle_bus_src", 64'(b4.cdb_src[3:2]),  64'(0));
    drain4(10, "t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
